// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, reset PC,
// exception codes for the CP0 side and the fetch-timeout default.
package ifetch_unit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT       = 32'hBFC0_0000;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_IBE  = 5'd6;

    typedef enum logic {
        CAUSE_ADEL = 1'b0,
        CAUSE_IBE  = 1'b1
    } fault_cause_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    function automatic logic [4:0] exc_code(input fault_cause_e cause);
        return (cause == CAUSE_ADEL) ? EXC_ADEL : EXC_IBE;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// REQ-phase watchdog for ifetch_unit: counts REQ cycles without an ack and
// flags the cycle on which the limit is reached. Exists only with FETCH_TIMEOUT_EN.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_req,
    input  logic ack,
    output logic expired
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Held at zero outside REQ so every REQ entry starts a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (!in_req) begin
            cnt_d = '0;
        end else if (!ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = in_req && (cnt_q == LAST_CNT);

endmodule
`endif

// File: rtl/ifetch_unit.sv
// Multicycle instruction fetch: latches PC, runs one outstanding memory read,
// fills IR and reports AdEL/IBE faults. Optional REQ timeout via FETCH_TIMEOUT_EN.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic [31:0] PC_in,
    input  logic        fetch_start,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [31:0] IR,
    output logic [31:0] PC4,
    output logic        ir_valid,
    output logic        adel,
    output logic        ibe,
    output logic [31:0] BadVAddr,
    output logic        busy
);

    logic [1:0]   state_q,    state_d;
    logic [31:0]  pc_q,       pc_d;
    logic [31:0]  ir_q,       ir_d;
    logic [31:0]  badvaddr_q, badvaddr_d;
    logic         drop_q,     drop_d;
    fault_cause_e cause_q,    cause_d;
    logic         timeout_hit;
    logic         discard;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (Clk),
        .reset_n (reset_n),
        .in_req  (state_q == ST_REQ),
        .ack     (mem_ack),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // A same-cycle flush counts as an earlier one: the response is thrown away.
    assign discard = drop_q || flush;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        badvaddr_d = badvaddr_q;
        drop_d     = drop_q;
        cause_d    = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_start && !flush) begin
                    pc_d   = PC_in;
                    drop_d = 1'b0;
                    if (is_misaligned(PC_in)) begin
                        badvaddr_d = PC_in;
                        cause_d    = CAUSE_ADEL;
                        state_d    = ST_FAULT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    drop_d = 1'b0;
                    if (discard) begin
                        state_d = ST_IDLE;
                    end else if (mem_err) begin
                        badvaddr_d = pc_q;
                        cause_d    = CAUSE_IBE;
                        state_d    = ST_FAULT;
                    end else begin
                        ir_d    = mem_rdata;
                        state_d = ST_DONE;
                    end
                end else if (timeout_hit) begin
                    drop_d = 1'b0;
                    if (discard) begin
                        state_d = ST_IDLE;
                    end else begin
                        badvaddr_d = pc_q;
                        cause_d    = CAUSE_IBE;
                        state_d    = ST_FAULT;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            badvaddr_q <= '0;
            drop_q     <= 1'b0;
            cause_q    <= CAUSE_ADEL;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            badvaddr_q <= badvaddr_d;
            drop_q     <= drop_d;
            cause_q    <= cause_d;
        end
    end

    assign mem_addr = {pc_q[31:2], 2'b00};
    assign mem_req  = (state_q == ST_REQ);
    assign IR       = ir_q;
    assign PC4      = pc_q + 32'd4;
    assign ir_valid = (state_q == ST_DONE);
    assign adel     = (state_q == ST_FAULT) && (cause_q == CAUSE_ADEL);
    assign ibe      = (state_q == ST_FAULT) && (cause_q == CAUSE_IBE);
    assign BadVAddr = badvaddr_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed cases plus randomized fetches
// checked against a transaction-level model of the fetch rules.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic [31:0] PC_in;
  logic        fetch_start;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] IR;
  logic [31:0] PC4;
  logic        ir_valid;
  logic        adel;
  logic        ibe;
  logic [31:0] BadVAddr;
  logic        busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_ir;
  logic [31:0] m_bad;
  logic [31:0] m_pc;

  always #5 Clk = ~Clk;

`ifdef FETCH_TIMEOUT_EN
  ifetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(4)) dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .PC_in       (PC_in),
    .fetch_start (fetch_start),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err),
    .IR          (IR),
    .PC4         (PC4),
    .ir_valid    (ir_valid),
    .adel        (adel),
    .ibe         (ibe),
    .BadVAddr    (BadVAddr),
    .busy        (busy)
  );
`else
  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .PC_in       (PC_in),
    .fetch_start (fetch_start),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err),
    .IR          (IR),
    .PC4         (PC4),
    .ir_valid    (ir_valid),
    .adel        (adel),
    .ibe         (ibe),
    .BadVAddr    (BadVAddr),
    .busy        (busy)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One complete fetch; outcome predicted from the fetch rules alone.
  task automatic do_fetch(input logic [31:0] pc, input int waits, input bit err,
                          input int flush_at, input logic [31:0] rdata, input bit noise);
    bit dropped;
    dropped     = 1'b0;
    PC_in       = pc;
    fetch_start = 1'b1;
    flush       = 1'b0;
    step();
    fetch_start = 1'b0;
    m_pc        = pc;
    if (pc[1:0] != 2'b00) begin
      m_bad = pc;
      chk("adel_pulse", adel, 1);
      chk("adel_no_ibe", ibe, 0);
      chk("adel_no_req", mem_req, 0);
      chk("adel_busy", busy, 1);
      chk("adel_badvaddr", BadVAddr, m_bad);
      chk("adel_ir", IR, m_ir);
      step();
      chk("adel_end", adel, 0);
      chk("adel_idle", busy, 0);
      chk("adel_no_req2", mem_req, 0);
      chk("adel_pc4", PC4, m_pc + 32'd4);
      return;
    end
    for (int c = 0; c <= waits; c++) begin
      chk("req_mem_req", mem_req, 1);
      chk("req_mem_addr", mem_addr, pc);
      chk("req_busy", busy, 1);
      chk("req_no_pulse", {ir_valid, adel, ibe}, 0);
      if (noise) begin
        fetch_start = 1'b1;
        PC_in       = $urandom;
      end
      flush = (c == flush_at);
      if (c == flush_at) dropped = 1'b1;
      mem_ack   = (c == waits);
      mem_err   = (c == waits) ? err : (noise ? 1'($urandom) : 1'b0);
      mem_rdata = (c == waits) ? rdata : $urandom;
      step();
      mem_ack = 1'b0;
      mem_err = 1'b0;
      flush   = 1'b0;
    end
    if (dropped) begin
      chk("drop_idle", busy, 0);
      chk("drop_no_pulse", {ir_valid, adel, ibe}, 0);
      chk("drop_ir", IR, m_ir);
      chk("drop_badvaddr", BadVAddr, m_bad);
      chk("drop_no_req", mem_req, 0);
    end else if (err) begin
      m_bad = pc;
      chk("ibe_pulse", ibe, 1);
      chk("ibe_no_valid", {ir_valid, adel}, 0);
      chk("ibe_badvaddr", BadVAddr, m_bad);
      chk("ibe_ir", IR, m_ir);
      chk("ibe_no_req", mem_req, 0);
      step();
      chk("ibe_end", ibe, 0);
      chk("ibe_idle", busy, 0);
    end else begin
      m_ir = rdata;
      chk("done_valid", ir_valid, 1);
      chk("done_ir", IR, m_ir);
      chk("done_no_exc", {adel, ibe}, 0);
      chk("done_no_req", mem_req, 0);
      step();
      chk("done_end", ir_valid, 0);
      chk("done_idle", busy, 0);
      chk("done_ir_hold", IR, m_ir);
    end
    fetch_start = 1'b0;
    chk("fetch_pc4", PC4, m_pc + 32'd4);
    chk("fetch_badvaddr", BadVAddr, m_bad);
  endtask

  initial begin
    int max_waits;
    reset_n     = 1'b0;
    PC_in       = '0;
    fetch_start = 1'b0;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    mem_err     = 1'b0;
    m_ir        = '0;
    m_bad       = '0;
    m_pc        = RST_PC;
`ifdef FETCH_TIMEOUT_EN
    max_waits = 3;
`else
    max_waits = 6;
`endif

    // Reset
    step();
    step();
    chk("rst_ir", IR, 0);
    chk("rst_pc4", PC4, 32'hBFC0_0004);
    chk("rst_mem_addr", mem_addr, RST_PC);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_badvaddr", BadVAddr, 0);
    chk("rst_pulses", {ir_valid, adel, ibe}, 0);
    reset_n = 1'b1;
    step();
    chk("rst_release_idle", busy, 0);

    // Directed cases
    do_fetch(32'hBFC0_0010, 3, 1'b0, -1, 32'h3C1D_8000, 1'b0);
    chk("normal_pc4", PC4, 32'hBFC0_0014);
    do_fetch(32'h8000_0182, 0, 1'b0, -1, 32'h0, 1'b0);
    do_fetch(32'h0040_0000, 0, 1'b1, -1, 32'h1234_5678, 1'b0);
    do_fetch(32'h0040_0100, 2, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
    do_fetch(32'h0040_0200, 1, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
    do_fetch(32'hFFFF_FFFC, 0, 1'b0, -1, 32'hCAFE_F00D, 1'b0);
    chk("wrap_pc4", PC4, 32'h0000_0000);

    // Flush in IDLE blocks a same-cycle fetch_start
    PC_in       = 32'h0000_1000;
    fetch_start = 1'b1;
    flush       = 1'b1;
    step();
    fetch_start = 1'b0;
    flush       = 1'b0;
    chk("idle_flush_busy", busy, 0);
    chk("idle_flush_req", mem_req, 0);
    chk("idle_flush_pc4", PC4, m_pc + 32'd4);

    // Late ack in IDLE is ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    chk("late_ack_ir", IR, m_ir);
    chk("late_ack_idle", {busy, ir_valid, ibe}, 0);

`ifdef FETCH_TIMEOUT_EN
    // Timeout with no ack: ibe after four REQ cycles
    PC_in       = 32'h0000_2000;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    m_pc        = 32'h0000_2000;
    for (int unsigned c = 0; c < 4; c++) begin
      chk("to_req", mem_req, 1);
      step();
    end
    m_bad = 32'h0000_2000;
    chk("to_ibe", ibe, 1);
    chk("to_req_low", mem_req, 0);
    chk("to_badvaddr", BadVAddr, m_bad);
    step();
    chk("to_idle", busy, 0);

    // Timeout after flush: silent return to IDLE
    PC_in       = 32'h0000_3000;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    m_pc        = 32'h0000_3000;
    for (int unsigned c = 0; c < 4; c++) begin
      chk("to_flush_req", mem_req, 1);
      flush = (c == 1);
      step();
      flush = 1'b0;
    end
    chk("to_flush_idle", busy, 0);
    chk("to_flush_no_pulse", {ir_valid, adel, ibe}, 0);
    chk("to_flush_badvaddr", BadVAddr, m_bad);

    // Ack on the fourth REQ cycle wins over the timeout
    do_fetch(32'h0000_4000, 3, 1'b0, -1, 32'h0BAD_F00D, 1'b0);
`endif

    // Randomized fetches
    for (int unsigned i = 0; i < 200; i++) begin
      logic [31:0] pc;
      int          waits;
      int          fl;
      pc = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        if (pc[1:0] == 2'b00) pc[1:0] = 2'($urandom_range(1, 3));
      end else begin
        pc[1:0] = 2'b00;
      end
      waits = $urandom_range(0, max_waits);
      fl    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, waits)) : -1;
      do_fetch(pc, waits, ($urandom_range(0, 4) == 0), fl, $urandom,
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("gap_idle", busy, 0);
      end
    end

    // Reset asserted mid-REQ
    PC_in       = 32'h0000_8000;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("midrst_req", mem_req, 1);
    reset_n = 1'b0;
    step();
    m_ir  = '0;
    m_bad = '0;
    m_pc  = RST_PC;
    chk("midrst_req_low", mem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ir", IR, m_ir);
    chk("midrst_pc4", PC4, m_pc + 32'd4);
    chk("midrst_addr", mem_addr, RST_PC);
    reset_n   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_8888;
    step();
    mem_ack = 1'b0;
    chk("midrst_late_ack_ir", IR, m_ir);
    chk("midrst_late_ack_idle", {busy, ir_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
